gf180mcu_osu_sc_12t_tdm_demux: RTL
==================================

// Module: gf180mcu_osu_sc_12T_tdm_demux
//
// PURPOSE
//  Registered 1:LANES demultiplexer, the receive-side inverse of the 2:1 mux cell.
//  Accepts one WIDTH-bit word per handshake and steers it into one of LANES
//  output holding registers, each with its own valid/ready pair.
//  Lane is chosen by explicit Sel, or by an internal round-robin slot counter
//  realigned by SYNC (TDM de-interleave).
//  Sits after a mux-based serializer/arbiter to restore per-source streams.
//
// PARAMETERS
//  WIDTH  1  data word width in bits (>=1)
//  LANES  2  number of output lanes (>=2); SELW = max(1,$clog2(LANES)) localparam
//  AUTO   0  0: lane from Sel; 1: lane from internal slot counter, Sel ignored
//
// PORTS
//  CLK       in   1            clock, all state updates on rising edge
//  RST       in   1            synchronous reset, active-high
//  D         in   WIDTH        input data word
//  Sel       in   SELW         target lane (AUTO=0 only)
//  SYNC      in   1            AUTO=1: force this word to lane 0, realign slot
//  IN_VALID  in   1            D/Sel/SYNC valid this cycle
//  IN_READY  out  1            block accepts D this cycle
//  Y         out  LANES*WIDTH  lane i data at Y[i*WIDTH +: WIDTH]
//  Y_VALID   out  LANES        lane i holds an unconsumed word
//  Y_READY   in   LANES        downstream of lane i consumes this cycle
//  ERR       out  1            sticky: out-of-range Sel accepted (word dropped)
//
// BEHAVIOUR
//  - Reset (RST=1 at edge): all full[i]=0, Y=0, slot=0, ERR=0; RST wins over
//    every other event; in-flight words discarded, Y_VALID=0 the next cycle.
//  - Target t: AUTO=0 -> Sel; AUTO=1 -> (SYNC ? 0 : slot).
//  - IN_READY = !full[t] | Y_READY[t] (combinational); if Sel>=LANES, IN_READY=1.
//  - Accept = IN_VALID & IN_READY. Pop[i] = Y_VALID[i] & Y_READY[i].
//  - On accept to valid t: reg[t]<=D, full[t]<=1. Latency 1: word on Y/Y_VALID
//    the cycle after acceptance. Simultaneous pop+accept on same lane: full stays
//    1, new word replaces old, no bubble. Pop alone: full[i]<=0.
//  - Y[i] holds value stable while Y_VALID[i]=1 and Y_READY[i]=0; Y[i] keeps last
//    word after pop (don't-care, but must not change without accept).
//  - Lanes independent: a full stalled lane blocks only words targeting it.
//  - Sel>=LANES (non-power-of-2 LANES) on accept: word dropped, ERR<=1 until RST.
//  - Slot counter (AUTO=1): on accept, slot<=(t==LANES-1)?0:t+1; no accept with
//    SYNC=1 -> slot<=0; else hold. Wraps LANES-1 -> 0.
//  - No combinational path from D to Y; Y_VALID, Y, ERR are register outputs.
//
// TESTING
//  1 AUTO=0,LANES=2,WIDTH=8: D=8'hA5,Sel=1,IN_VALID=1 -> next cycle Y[15:8]=A5,
//    Y_VALID=2'b10; Y_READY=2'b10 one cycle -> Y_VALID=2'b00.
//  2 Backpressure: lane0 full, Y_READY=0, Sel=0 -> IN_READY=0, Y[7:0] stable;
//    Sel=1 same cycle -> IN_READY=1, lane1 loads. Raise Y_READY[0] with
//    Sel=0,D=3C -> same-cycle pop+load, Y_VALID[0] stays 1, Y[7:0]=3C.
//  3 AUTO=1,LANES=3: stream 1,2,3,4,5 all ready -> lanes 0,1,2,0,1;
//    assert SYNC with word 6 -> lane 0, next word 7 -> lane 1.
//  4 AUTO=0,LANES=3: Sel=3 with IN_VALID -> IN_READY=1, no Y_VALID change,
//    ERR=1 and stays 1 until RST.
//  5 RST=1 with all lanes full and IN_VALID=1 -> next cycle Y_VALID=0, Y=0,
//    ERR=0, slot=0; first AUTO word after reset lands in lane 0.
//  6 Random valid/ready per lane, 10k cycles: scoreboard per-lane order, no loss,
//    no duplication.

Source files
------------

// File: rtl/gf180mcu_osu_sc_12t_tdm_demux_if.sv
// Bundle of the demux input handshake, per-lane output handshakes and the sticky error flag.
// The master side feeds words and consumes lanes; the slave side is the demux itself.
interface gf180mcu_osu_sc_12t_tdm_demux_if #(
    parameter int WIDTH = 1,
    parameter int LANES = 2
);
    localparam int SELW = (LANES > 2) ? $clog2(LANES) : 1;

    logic [WIDTH-1:0]       d;
    logic [SELW-1:0]        sel;
    logic                   sync;
    logic                   in_valid;
    logic                   in_ready;
    logic [LANES*WIDTH-1:0] y;
    logic [LANES-1:0]       y_valid;
    logic [LANES-1:0]       y_ready;
    logic                   err;

    modport master (
        output d, sel, sync, in_valid, y_ready,
        input  in_ready, y, y_valid, err
    );

    modport slave (
        input  d, sel, sync, in_valid, y_ready,
        output in_ready, y, y_valid, err
    );
endinterface

// File: rtl/gf180mcu_osu_sc_12t_tdm_demux.sv
// Registered 1:LANES demultiplexer: each accepted word lands in one lane holding register,
// chosen by sel or, in AUTO mode, by a round-robin slot counter that sync realigns to lane 0.
module gf180mcu_osu_sc_12t_tdm_demux #(
    parameter int WIDTH = 1,
    parameter int LANES = 2,
    parameter int AUTO  = 0
) (
    input logic clk,
    input logic rst,
    gf180mcu_osu_sc_12t_tdm_demux_if.slave bus
);
    localparam int              SELW      = (LANES > 2) ? $clog2(LANES) : 1;
    localparam bit              AUTO_EN   = (AUTO != 32'sd0);
    localparam logic [SELW:0]   LANES_W   = (SELW + 1)'(LANES);
    localparam logic [SELW-1:0] LAST_SLOT = SELW'(LANES - 1);

    logic [SELW-1:0]  target_s;
    logic [SELW-1:0]  slot_next_s;
    logic [SELW-1:0]  slot_r;
    logic             in_range_s;
    logic             in_ready_s;
    logic             accept_s;
    logic [LANES-1:0] hit_s;
    logic [LANES-1:0] load_s;
    logic [LANES-1:0] pop_s;
    logic [LANES-1:0] full_r;
    logic [WIDTH-1:0] data_r [LANES];
    logic             err_r;

    // Target lane decode, per-lane readiness and handshake qualification
    always_comb begin
        target_s    = bus.sel;
        in_range_s  = 1'b0;
        hit_s       = {LANES{1'b0}};
        in_ready_s  = 1'b1;
        accept_s    = 1'b0;
        load_s      = {LANES{1'b0}};
        pop_s       = {LANES{1'b0}};
        slot_next_s = {SELW{1'b0}};

        if (AUTO_EN) begin
            if (bus.sync) begin
                target_s = {SELW{1'b0}};
            end else begin
                target_s = slot_r;
            end
        end else begin
            target_s = bus.sel;
        end

        // An out-of-range sel (non power-of-two LANES) is swallowed: always ready, never loads
        in_range_s = ({1'b0, target_s} < LANES_W);
        for (int i = 0; i < LANES; i++) begin
            hit_s[i] = in_range_s && (target_s == SELW'(i));
        end

        if (in_range_s) begin
            in_ready_s = |(hit_s & (~full_r | bus.y_ready));
        end else begin
            in_ready_s = 1'b1;
        end

        accept_s = bus.in_valid & in_ready_s;
        load_s   = hit_s & {LANES{accept_s}};
        pop_s    = full_r & bus.y_ready;

        if (target_s == LAST_SLOT) begin
            slot_next_s = {SELW{1'b0}};
        end else begin
            slot_next_s = target_s + SELW'(1'b1);
        end
    end

    // Lane registers, occupancy flags, slot counter and sticky error
    always_ff @(posedge clk) begin
        if (rst) begin
            full_r <= {LANES{1'b0}};
            slot_r <= {SELW{1'b0}};
            err_r  <= 1'b0;
            for (int i = 0; i < LANES; i++) begin
                data_r[i] <= {WIDTH{1'b0}};
            end
        end else begin
            // A load on a lane being popped in the same cycle keeps it full: no bubble
            for (int i = 0; i < LANES; i++) begin
                if (load_s[i]) begin
                    data_r[i] <= bus.d;
                    full_r[i] <= 1'b1;
                end else if (pop_s[i]) begin
                    full_r[i] <= 1'b0;
                end
            end

            if (accept_s && !in_range_s) begin
                err_r <= 1'b1;
            end

            if (accept_s) begin
                slot_r <= slot_next_s;
            end else if (bus.sync) begin
                slot_r <= {SELW{1'b0}};
            end
        end
    end

    for (genvar g = 0; g < LANES; g++) begin : g_lane_out
        assign bus.y[g*WIDTH +: WIDTH] = data_r[g];
    end

    assign bus.y_valid  = full_r;
    assign bus.err      = err_r;
    assign bus.in_ready = in_ready_s;

endmodule
